// File: rtl/coef_prog_streamer.sv
// Coefficient-programming stream initiator: buffers processor writes in a FWFT FIFO and
// streams them to a filter's tap_din handshake, tracking count, done and timeout status.
module coef_prog_streamer #(
  parameter int unsigned G_TAP_WIDTH       = 16,
  parameter int unsigned G_FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned G_MAX_TAPS        = 129,
  parameter int unsigned G_DONE_TIMEOUT    = 64,
  localparam int unsigned C_CW             = $clog2(G_MAX_TAPS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         start,
  input  logic [C_CW-1:0]              num_taps,
  input  logic [G_TAP_WIDTH-1:0]       wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic [G_TAP_WIDTH-1:0]       prog_dout,
  output logic                         prog_valid,
  input  logic                         prog_ready,
  input  logic                         prog_done,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [C_CW-1:0]              words_sent,
  output logic [G_FIFO_DEPTH_LOG2:0]   fifo_level
);

  localparam int unsigned AW    = G_FIFO_DEPTH_LOG2;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned TW    = $clog2(G_DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StStream, StWaitDone, StDone, StError} state_e;

  state_e state_q, state_d;

  logic [G_TAP_WIDTH-1:0] mem_q [Depth];
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic [G_TAP_WIDTH-1:0] dout_q, dout_d;
  logic [C_CW-1:0]        count_q, count_d, sent_q, sent_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   done_q, done_d, error_q, error_d, busy_q, busy_d;
  logic                   empty, full, push, pop, taps_ok, idle_like;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = wr_valid && wr_ready;
  assign pop       = prog_valid && prog_ready;
  assign taps_ok   = (num_taps != '0) && (num_taps <= C_CW'(G_MAX_TAPS));
  assign idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StError);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // prog_dout is a registered copy of the FIFO head; it holds while the FIFO is empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q;
    if (push && !pop) level_d = level_q + PW'(1);
    else if (!push && pop) level_d = level_q - PW'(1);
    dout_d = dout_q;
    if (level_d != '0) begin
      dout_d = (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) ? wr_data
                                                                 : mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else if (!enable) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StError: if (start) state_d = taps_ok ? StStream : StError;
      StStream: begin
        if (prog_done) state_d = StError;
        else if (pop && (sent_q + C_CW'(1) == count_q)) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (prog_done) state_d = StDone;
        else if (timer_q == TW'(G_DONE_TIMEOUT)) state_d = StError;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ready   = enable && !full && !reset;
    prog_valid = enable && (state_q == StStream) && !empty;
    count_d    = count_q;
    sent_d     = sent_q;
    done_d     = done_q;
    error_d    = error_q;
    if (idle_like && start) begin
      done_d  = 1'b0;
      error_d = !taps_ok;
      if (taps_ok) begin
        count_d = num_taps;
        sent_d  = '0;
      end
    end
    if (pop) sent_d = sent_q + C_CW'(1);
    if ((state_q == StWaitDone) && (state_d == StDone)) done_d = 1'b1;
    if (!idle_like && (state_d == StError)) error_d = 1'b1;
    timer_d = ((state_q == StWaitDone) && (state_d == StWaitDone)) ? timer_q + TW'(1) : '0;
    busy_d  = (state_d == StStream) || (state_d == StWaitDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      timer_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (!enable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      timer_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      timer_q  <= timer_d;
      done_q   <= done_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
    end
  end

  assign prog_dout  = dout_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words_sent = sent_q;
  assign fifo_level = level_q;

endmodule
